// File: rtl/motor_cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// motor_cmd_seq_pkg
// Shared definitions for the four-motor command sequencer:
//   - DUTY_W / duty_t : width and type of one motor duty byte
//   - N_MOTORS        : number of motor channels packed on the buses
//   - state_e         : sequencer FSM encoding (exposed on the state port)
//   - clamp_duty()    : saturate a requested duty into an allowed window
// -----------------------------------------------------------------------------
package motor_cmd_seq_pkg;

  localparam int DUTY_W   = 8;
  localparam int N_MOTORS = 4;
  localparam int BUS_W    = N_MOTORS * DUTY_W;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_e;

  function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/motor_cmd_seq_if.sv
// -----------------------------------------------------------------------------
// motor_cmd_seq_if
// Command bus carrying four packed motor duty targets with a valid/ready
// handshake. A command transfers on a clock where cmd_valid and cmd_ready
// are both high.
//   cmd_valid : master -> slave, command present
//   cmd_ready : slave  -> master, sequencer can take a command
//   cmd_duty  : master -> slave, motor k target at bits [8k+7:8k]
// -----------------------------------------------------------------------------
interface motor_cmd_seq_if;
  import motor_cmd_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [BUS_W-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_duty, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_duty, output cmd_ready);

endinterface

// File: rtl/motor_cmd_seq_slew_channel.sv
// -----------------------------------------------------------------------------
// slew_channel
// One motor duty register that walks toward its target by at most SLEW_STEP
// per tick and never overshoots.
//   clk    : system clock
//   reset  : synchronous active-low reset, forces duty to 0
//   tick   : one-cycle slew strobe
//   target : requested duty
//   duty   : current (slew-limited) duty
// -----------------------------------------------------------------------------
module slew_channel
  import motor_cmd_seq_pkg::*;
#(
  parameter int SLEW_STEP = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  tick,
  input  duty_t target,
  output duty_t duty
);

  localparam logic [DUTY_W:0] STEP_9 = (DUTY_W+1)'(SLEW_STEP);
  localparam duty_t           STEP_D = duty_t'(SLEW_STEP);

  logic            up;
  logic [DUTY_W:0] diff;
  duty_t           step;
  duty_t           duty_next;

  // Magnitude of the error is formed in 9 bits so the subtraction cannot
  // wrap; the step is then limited to that magnitude, which keeps the
  // 8-bit add/subtract inside 0..255.
  always_comb begin
    up        = (target > duty);
    diff      = up ? ({1'b0, target} - {1'b0, duty})
                   : ({1'b0, duty} - {1'b0, target});
    step      = (diff > STEP_9) ? STEP_D : diff[DUTY_W-1:0];
    duty_next = up ? (duty + step) : (duty - step);
  end

  always_ff @(posedge clk) begin
    if (!reset)    duty <= '0;
    else if (tick) duty <= duty_next;
  end

endmodule

// File: rtl/motor_cmd_seq.sv
// -----------------------------------------------------------------------------
// motor_cmd_seq
// Arming / failsafe sequencer for four motors. Accepts packed duty commands
// while ARMED, clamps them to [IDLE_DUTY, MAX_DUTY], and slew-limits every
// channel on a RAMP_HZ tick. A watchdog forces a controlled ramp-down if no
// command is accepted for WDOG_TICKS ticks.
//   clk        : system clock
//   reset      : synchronous active-low reset
//   arm_req    : request to arm
//   disarm_req : request a controlled ramp-down
//   failsafe   : external fault, forces ramp-down
//   cmd        : command bus (slave side) -- valid / ready / 32-bit duties
//   duty_cycle : four current duties, motor k at [8k+7:8k]
//   armed      : high only in ARMED
//   state      : current FSM state
// -----------------------------------------------------------------------------
module motor_cmd_seq
  import motor_cmd_seq_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int RAMP_HZ    = 1000,
  parameter int SLEW_STEP  = 2,
  parameter int IDLE_DUTY  = 20,
  parameter int MAX_DUTY   = 240,
  parameter int WDOG_TICKS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_req,
  input  logic             disarm_req,
  input  logic             failsafe,
  motor_cmd_seq_if.slave   cmd,
  output logic [BUS_W-1:0] duty_cycle,
  output logic             armed,
  output logic [1:0]       state
);

  localparam int TICK_DIV = CLK_FREQ / RAMP_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WDOG_W   = $clog2(WDOG_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_TICKS);
  localparam duty_t             IDLE_D    = duty_t'(IDLE_DUTY);
  localparam duty_t             MAX_D     = duty_t'(MAX_DUTY);

  state_e                           state_q, state_d;
  logic [TICK_W-1:0]                tick_cnt;
  logic                             tick;
  logic [WDOG_W-1:0]                wdog_cnt;
  logic                             wdog_expired;
  logic                             cmd_ready_int;
  logic                             cmd_accept;
  logic                             all_idle;
  logic                             all_zero;
  logic [N_MOTORS-1:0][DUTY_W-1:0]  tgt_q, tgt_d;
  logic [N_MOTORS-1:0][DUTY_W-1:0]  duty_q;

  // ---------------------------------------------------------------------------
  // Slew tick: free-running divider, one-cycle strobe on the last count.
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Command handshake. Ready is suppressed whenever a shutdown input is
  // present so a command can never race a failsafe or disarm on one clock.
  // ---------------------------------------------------------------------------
  assign cmd_ready_int = reset && (state_q == ST_ARMED) && !failsafe && !disarm_req;
  assign cmd.cmd_ready = cmd_ready_int;
  assign cmd_accept    = cmd.cmd_valid && cmd_ready_int;

  // ---------------------------------------------------------------------------
  // Watchdog: counts ticks while ARMED, cleared outside ARMED (so it starts
  // from zero on entry) and on every accepted command. Holds at the limit.
  // ---------------------------------------------------------------------------
  assign wdog_expired = (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (!reset)                                wdog_cnt <= '0;
    else if (state_q != ST_ARMED || cmd_accept) wdog_cnt <= '0;
    else if (tick && !wdog_expired)            wdog_cnt <= wdog_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Duty status used by the FSM (registered duties, not targets).
  // ---------------------------------------------------------------------------
  always_comb begin
    all_idle = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < N_MOTORS; k++) begin
      if (duty_q[k] != IDLE_D) all_idle = 1'b0;
      if (duty_q[k] != '0)     all_zero = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. Shutdown inputs outrank arming in every state.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISARMED: if (arm_req && !failsafe && !disarm_req) state_d = ST_ARMING;
      ST_ARMING: begin
        if (failsafe || disarm_req) state_d = ST_FAILSAFE;
        else if (all_idle)          state_d = ST_ARMED;
      end
      ST_ARMED:    if (failsafe || disarm_req || wdog_expired) state_d = ST_FAILSAFE;
      ST_FAILSAFE: if (all_zero) state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_DISARMED;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Targets follow the state being entered: zero when disarmed or shutting
  // down, idle while spinning up, command (clamped) while armed. Only the
  // targets jump; the duties themselves always ramp through slew_channel.
  // ---------------------------------------------------------------------------
  always_comb begin
    tgt_d = tgt_q;
    for (int k = 0; k < N_MOTORS; k++) begin
      unique case (state_d)
        ST_DISARMED, ST_FAILSAFE: tgt_d[k] = '0;
        ST_ARMING:                tgt_d[k] = IDLE_D;
        ST_ARMED: if (cmd_accept)
          tgt_d[k] = clamp_duty(cmd.cmd_duty[k*DUTY_W +: DUTY_W], IDLE_D, MAX_D);
      endcase
    end
  end

  // NOTE: the target array is a few discrete flops rather than a RAM, so it is
  // reset explicitly; an unreset target could spin a motor right after reset.
  always_ff @(posedge clk) begin
    if (!reset) tgt_q <= '0;
    else        tgt_q <= tgt_d;
  end

  // ---------------------------------------------------------------------------
  // Per-motor slew limiters.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_MOTORS; k++) begin : g_ch
    slew_channel #(
      .SLEW_STEP (SLEW_STEP)
    ) u_slew (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .target (tgt_q[k]),
      .duty   (duty_q[k])
    );
  end

  assign duty_cycle = duty_q;
  assign armed      = (state_q == ST_ARMED);
  assign state      = state_q;

endmodule

// File: tb/tb_motor_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_motor_cmd_seq
// Drives directed and random stimulus into motor_cmd_seq and compares every
// cycle against a behavioural model held in plain integers.
// -----------------------------------------------------------------------------
module tb_motor_cmd_seq;
  import motor_cmd_seq_pkg::*;

  localparam int CLK_FREQ   = 1000;
  localparam int RAMP_HZ    = 100;
  localparam int SLEW_STEP  = 4;
  localparam int IDLE_DUTY  = 20;
  localparam int MAX_DUTY   = 240;
  localparam int WDOG_TICKS = 50;
  localparam int TICK_DIV   = CLK_FREQ / RAMP_HZ;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm_req = 1'b0;
  logic        disarm_req = 1'b0;
  logic        failsafe = 1'b0;
  logic [31:0] duty_cycle;
  logic        armed;
  logic [1:0]  state;

  motor_cmd_seq_if cmd_if ();

  motor_cmd_seq #(
    .CLK_FREQ   (CLK_FREQ),
    .RAMP_HZ    (RAMP_HZ),
    .SLEW_STEP  (SLEW_STEP),
    .IDLE_DUTY  (IDLE_DUTY),
    .MAX_DUTY   (MAX_DUTY),
    .WDOG_TICKS (WDOG_TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm_req    (arm_req),
    .disarm_req (disarm_req),
    .failsafe   (failsafe),
    .cmd        (cmd_if),
    .duty_cycle (duty_cycle),
    .armed      (armed),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: 0=disarmed 1=arming 2=armed 3=failsafe, duties as ints.
  // ---------------------------------------------------------------------------
  int m_state = 0;
  int m_phase = 0;
  int m_wdog  = 0;
  int m_duty[4];
  int m_tgt[4];

  function automatic int clamp_int(input int v);
    if (v < IDLE_DUTY) return IDLE_DUTY;
    if (v > MAX_DUTY)  return MAX_DUTY;
    return v;
  endfunction

  task automatic model_step();
    bit is_tick, acc, all_idle, all_zero;
    int nst, d;
    logic [31:0] req;
    if (!reset) begin
      m_state = 0; m_phase = 0; m_wdog = 0;
      for (int k = 0; k < 4; k++) begin m_duty[k] = 0; m_tgt[k] = 0; end
      return;
    end
    is_tick = (m_phase == TICK_DIV - 1);
    m_phase = (m_phase + 1) % TICK_DIV;
    acc = (m_state == 2) && !failsafe && !disarm_req && cmd_if.cmd_valid;
    req = cmd_if.cmd_duty;
    all_idle = 1'b1; all_zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (m_duty[k] != IDLE_DUTY) all_idle = 1'b0;
      if (m_duty[k] != 0)         all_zero = 1'b0;
    end
    nst = m_state;
    case (m_state)
      0: if (arm_req && !failsafe && !disarm_req) nst = 1;
      1: if (failsafe || disarm_req) nst = 3; else if (all_idle) nst = 2;
      2: if (failsafe || disarm_req || m_wdog == WDOG_TICKS) nst = 3;
      default: if (all_zero) nst = 0;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (is_tick) begin
        d = m_tgt[k] - m_duty[k];
        if (d > 0)      m_duty[k] += (d < SLEW_STEP) ? d : SLEW_STEP;
        else if (d < 0) m_duty[k] -= (-d < SLEW_STEP) ? -d : SLEW_STEP;
      end
    end
    if (m_state != 2 || acc)                m_wdog = 0;
    else if (is_tick && m_wdog < WDOG_TICKS) m_wdog++;
    for (int k = 0; k < 4; k++) begin
      if (nst == 0 || nst == 3) m_tgt[k] = 0;
      else if (nst == 1)        m_tgt[k] = IDLE_DUTY;
      else if (acc)             m_tgt[k] = clamp_int(int'(req[k*8 +: 8]));
    end
    m_state = nst;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison, settled well after the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      check("state", {30'd0, state}, 32'(m_state));
      check("duty_cycle", duty_cycle,
            {8'(m_duty[3]), 8'(m_duty[2]), 8'(m_duty[1]), 8'(m_duty[0])});
      check("armed", {31'd0, armed}, {31'd0, m_state == 2});
      check("cmd_ready", {31'd0, cmd_if.cmd_ready},
            {31'd0, reset && m_state == 2 && !failsafe && !disarm_req});
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 3 time units after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(negedge clk);
    #3;
  endtask

  task automatic cycles(input int n);
    repeat (n) sync();
  endtask

  task automatic send_cmd(input logic [31:0] v);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = v;
    sync();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag,
                            output int waited);
    waited = 0;
    while (state !== s && waited < budget) begin
      sync();
      waited++;
    end
    check(tag, {30'd0, state}, {30'd0, s});
  endtask

  task automatic arm_and_wait();
    int w;
    arm_req = 1'b1;
    sync();
    arm_req = 1'b0;
    wait_state(2'd2, 120, "reach_armed", w);
  endtask

  initial begin
    int w;
    int waited_m0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = '0;

    // Reset held for several clocks.
    reset = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    cycles(3);
    check("rst_duty", duty_cycle, 32'h0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_armed", {31'd0, armed}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    reset = 1'b1;
    sync();
    check("ready_after_rst", {31'd0, cmd_if.cmd_ready}, 32'd0);

    // Arming spin-up to idle.
    arm_req = 1'b1;
    sync();
    arm_req = 1'b0;
    check("arm_state", {30'd0, state}, 32'd1);
    wait_state(2'd2, 120, "armed_state", w);
    check("armed_idle_duty", duty_cycle, 32'h14141414);
    check("armed_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    // Command with clamping on bytes 1, 2, 3.
    send_cmd(32'h0AFF0064);
    cycles(25 * TICK_DIV);
    check("m0_at_100", {24'd0, duty_cycle[7:0]}, 32'd100);
    check("m1_idle", {24'd0, duty_cycle[15:8]}, 32'd20);
    check("m3_idle", {24'd0, duty_cycle[31:24]}, 32'd20);
    send_cmd(32'h0AFF0064);
    cycles(40 * TICK_DIV);
    check("m2_clamped", duty_cycle, 32'h14F01464);

    // Watchdog expiry, then ramp-down from current duties.
    send_cmd(32'h0AFF0064);
    wait_state(2'd3, 600, "wdog_failsafe", w);
    check("wdog_window", {31'd0, (w >= 485 && w <= 515)}, 32'd1);
    check("fs_no_jump", {31'd0, duty_cycle[23:16] >= 8'd236}, 32'd1);
    wait_state(2'd0, 800, "fs_to_disarmed", w);
    check("disarmed_duty", duty_cycle, 32'h0);
    check("disarmed_armed", {31'd0, armed}, 32'd0);

    // Failsafe and command on the same clock.
    arm_and_wait();
    cycles(2);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 32'hC8C8C8C8;
    failsafe = 1'b1;
    #1;
    check("fs_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    sync();
    failsafe = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("fs_cmd_state", {30'd0, state}, 32'd3);
    cycles(3 * TICK_DIV);
    check("fs_cmd_no_rise", {31'd0, duty_cycle[7:0] <= 8'd20}, 32'd1);
    wait_state(2'd0, 300, "fs_cmd_disarmed", w);

    // Reset in the middle of a ramp.
    arm_and_wait();
    send_cmd(32'h000000C8);
    waited_m0 = 0;
    while (duty_cycle[7:0] != 8'd60 && waited_m0 < 400) begin
      sync();
      waited_m0++;
    end
    check("m0_reached_60", {24'd0, duty_cycle[7:0]}, 32'd60);
    reset = 1'b0;
    sync();
    check("midramp_rst_duty", duty_cycle, 32'h0);
    check("midramp_rst_state", {30'd0, state}, 32'd0);
    reset = 1'b1;

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      arm_req          = ($urandom_range(0, 19) == 0);
      disarm_req       = ($urandom_range(0, 299) == 0);
      failsafe         = ($urandom_range(0, 399) == 0);
      cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_duty  = $urandom;
      sync();
    end
    arm_req = 1'b0; disarm_req = 1'b0; failsafe = 1'b0; cmd_if.cmd_valid = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_cmd_seq.md
MOTOR_CMD_SEQ -- requirements
Module: motor_cmd_seq

Interface
REQ-001 Parameter CLK_FREQ, default 100000000: system clock frequency in Hz.
REQ-002 Parameter RAMP_HZ, default 1000: slew tick rate in Hz; TICK_DIV = CLK_FREQ/RAMP_HZ.
REQ-003 Parameter SLEW_STEP, default 2: maximum duty change per channel per tick.
REQ-004 Parameter IDLE_DUTY, default 20: armed minimum duty, also arming spin-up target.
REQ-005 Parameter MAX_DUTY, default 240: armed maximum duty.
REQ-006 Parameter WDOG_TICKS, default 100: ticks without an accepted command before failsafe.
REQ-007 clk  in  1  system clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 arm_req  in  1  request to arm (level or pulse).
REQ-010 disarm_req  in  1  request a controlled ramp-down.
REQ-011 failsafe  in  1  external fault; forces ramp-down.
REQ-012 cmd_valid  in  1  command-bus valid.
REQ-013 cmd_ready  out  1  command-bus ready.
REQ-014 cmd_duty  in  32  four 8-bit motor targets; motor k at bits [8k+7:8k].
REQ-015 duty_cycle  out  32  four 8-bit duties, same packing, one byte per downstream PWM_Gen instance.
REQ-016 armed  out  1  high only in ARMED.
REQ-017 state  out  2  current FSM state.

Function
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL pulse for one clk when count = TICK_DIV-1.
REQ-019 FSM states SHALL be DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.
REQ-020 Input priority SHALL be failsafe > disarm_req > arm_req.
REQ-021 DISARMED: targets 0; arm_req with failsafe low -> ARMING, all targets set to IDLE_DUTY.
REQ-022 ARMING: next state SHALL be ARMED once all four duty_cycle bytes equal IDLE_DUTY; on failsafe or disarm_req -> FAILSAFE instead.
REQ-023 ARMED: on failsafe, disarm_req, or watchdog expiry -> FAILSAFE.
REQ-024 FAILSAFE: all targets 0; next state SHALL be DISARMED once all four duty bytes equal 0; arm_req ignored.
REQ-025 cmd_ready SHALL be combinational: (state==ARMED) and not failsafe and not disarm_req.
REQ-026 Command SHALL be accepted on the clk where cmd_valid and cmd_ready are both high; targets update on the next clk edge.
REQ-027 Accepted bytes SHALL be clamped to [IDLE_DUTY, MAX_DUTY] before storage in the target registers.
REQ-028 Each channel's duty SHALL change only on tick, moving toward its target by min(SLEW_STEP, |target-duty|) and never overshooting.
REQ-029 Difference arithmetic SHALL use 9 bits; duty SHALL never wrap past 0 or 255.
REQ-030 Watchdog SHALL count ticks in ARMED and clear on ARMED entry and on each accepted command; expiry occurs at count WDOG_TICKS.
REQ-031 A command arriving with failsafe high on the same clk SHALL NOT be accepted.
REQ-032 Entering FAILSAFE SHALL start the ramp down from the current duty values with no step to 0.

Reset
REQ-033 While reset=0 at a clk edge: state=DISARMED, duty_cycle=0, targets=0, tick and watchdog counters=0, armed=0.
REQ-034 cmd_ready SHALL be 0 during reset and on the first clk after reset is released.
REQ-035 Reset asserted mid-ramp SHALL zero all duties at that clk edge, overriding any ramp.

Structure
REQ-036 A shared package SHALL hold the state encoding and the 8-bit duty typedef/width constant.
REQ-037 A sub-module, slew_channel, SHALL be instantiated four times (inputs: target, tick; output: duty).

Verification (CLK_FREQ=1000, RAMP_HZ=100, SLEW_STEP=4, IDLE_DUTY=20, MAX_DUTY=240, WDOG_TICKS=50)
REQ-038 Reset for 3 clk -> duty_cycle=0, state=0, armed=0, cmd_ready=0.
REQ-039 arm_req pulse -> state=1; duties step 4,8,..,20 every 10 clk; state=2 after the 5th tick; cmd_ready=1.
REQ-040 In ARMED, cmd_duty=0x0AFF0064 -> motor0 ramps 20->100 over 20 ticks; motor2 ramps to 240 (clamped); motors 1 and 3 stay at 20.
REQ-041 No command for 50 ticks -> state=3; duties ramp to 0 in 4-step decrements; then state=0 and armed=0.
REQ-042 failsafe and cmd_valid on the same clk -> cmd_ready=0, targets unchanged, state=3 next clk.
REQ-043 reset=0 while motor0=60 and ramping -> all duties 0 and state=0 on the next edge.
